window_3x3_generator: RTL and testbench
=======================================

// Module: window_3x3_generator
// PURPOSE
//  Raster-stream to 3x3 neighbourhood builder. It drives the denoise core's window
//  interface (iDataValid + a,b,c,d,fij,e,f,g,h). Input is one 8-bit pixel per
//  accepted beat, in raster order. Two internal line buffers plus a 3x3 shift array
//  emit one window per output pulse. Placed between the pixel source and the top module.
// PARAMETERS
//  IMG_WIDTH   256  pixels per row, >=3
//  IMG_HEIGHT  256  rows per frame, >=3
// PORTS
//  iClk          in   1  clock, rising edge
//  iRst          in   1  reset, asynchronous, active-high
//  iPixelValid   in   1  iv8Pixel/iFrameStart qualified
//  iFrameStart   in   1  with iPixelValid: this pixel is (row 0, col 0)
//  iv8Pixel      in   8  raster pixel
//  oReady        out  1  block accepts a pixel this cycle
//  oDataValid    out  1  one-cycle pulse: window outputs valid
//  ov8Pixel_a    out  8  (y-1,x-1)
//  ov8Pixel_b    out  8  (y-1,x)
//  ov8Pixel_c    out  8  (y-1,x+1)
//  ov8Pixel_d    out  8  (y,x-1)
//  ov8Pixel_fij  out  8  centre (y,x)
//  ov8Pixel_e    out  8  (y,x+1)
//  ov8Pixel_f    out  8  (y+1,x-1)
//  ov8Pixel_g    out  8  (y+1,x)
//  ov8Pixel_h    out  8  (y+1,x+1)
//  oFrameDone    out  1  one-cycle pulse, cycle after the frame's last window
// BEHAVIOUR
//  - Reset (async): all outputs 0 (oReady=0 while iRst high), FSM->IDLE, counters 0.
//    Line-buffer contents are don't-care. Reset mid-frame drops the frame; no further windows.
//  - Accept = iPixelValid & oReady. oReady=1 in IDLE/RUN, 0 in FLUSH.
//  - FSM: IDLE --accept&iFrameStart--> RUN. RUN --accept of (H-1,W-1)--> IDLE
//    (macro off) or FLUSH (macro on). FLUSH runs exactly W+1 cycles, then IDLE.
//  - IDLE ignores beats without iFrameStart.
//  - iFrameStart accepted in RUN: abort the current frame. That beat becomes (0,0).
//    No window of the old frame is emitted afterwards.
//  - Col/row counters advance on accept only; col wraps at W-1 and row increments.
//  - Acceptance of input index k (k=row*W+col) makes centre index k-(W+1) eligible.
//    Window registered; oDataValid/outputs appear the cycle after accept.
//    Latency is exactly 1 clk from accept to window pulse.
//  - Outputs hold their last value when oDataValid=0. Input gaps never change the window sequence.
//  - Macro off: pulse only for interior centres (1<=y<=H-2, 1<=x<=W-2).
//    (H-2)*(W-2) pulses per frame. oFrameDone is 1 clk after the pulse for (H-2,W-2).
//  - Window wiring/muxing: shift-array columns that straddle a row wrap must not leak
//    into the window. Interior windows never straddle.
//  - oDataValid and oFrameDone never assert in the same cycle.
// CONFIGURATION
//  WINDOW_BORDER_REPLICATE_EN
//  - undefined: interior-only output as above. No FLUSH state.
//  - defined: one window for every pixel, H*W pulses per frame, in raster centre order.
//    Out-of-image neighbours take the nearest in-image pixel (clamp row and col independently).
//    After the last pixel: FLUSH, W+1 self-timed cycles, oReady=0, one window per cycle.
//    These cycles emit the trailing W+1 centres. oFrameDone follows the pulse for (H-1,W-1).
// TESTING
//  W=H=4, pixel=4*row+col, continuous valid, macro off:
//  -> first pulse the clk after index 10, a..h=0,1,2,4,5,6,8,9,10.
//  -> 4 pulses total, last fij=10. oFrameDone 1 clk after the last pulse.
//  Same image, iPixelValid 1-of-3 random duty:
//  -> identical 4 window values; each pulse exactly 1 clk after its enabling accept.
//  Macro on, same image:
//  -> first pulse after index 5: a..h=0,0,1,0,0,1,4,4,5.
//  -> 16 pulses total; oReady low for exactly 5 clk after index 15.
//  -> last window a..h=10,11,11,14,15,15,14,15,15.
//  iFrameStart re-asserted at index 7 of frame A, then a full frame B (pixel=100+idx):
//  -> no frame-A window; frame B windows only, correct values.
//  iRst pulsed at index 9, then a clean frame:
//  -> all outputs 0 and oReady=0 during reset; next frame matches the first test exactly.
//  Beats without iFrameStart while IDLE:
//  -> ignored, no oDataValid.

Source files
------------

// File: rtl/window_3x3_generator_if.sv
// Pixel-in / window-out bundle for window_3x3_generator.
// The slave side is the generator; the master side is the pixel source and window consumer.
interface window_3x3_generator_if;
  logic       iPixelValid;
  logic       iFrameStart;
  logic [7:0] iv8Pixel;
  logic       oReady;
  logic       oDataValid;
  logic [7:0] ov8Pixel_a;
  logic [7:0] ov8Pixel_b;
  logic [7:0] ov8Pixel_c;
  logic [7:0] ov8Pixel_d;
  logic [7:0] ov8Pixel_fij;
  logic [7:0] ov8Pixel_e;
  logic [7:0] ov8Pixel_f;
  logic [7:0] ov8Pixel_g;
  logic [7:0] ov8Pixel_h;
  logic       oFrameDone;

  modport master (
    output iPixelValid, iFrameStart, iv8Pixel,
    input  oReady, oDataValid, oFrameDone,
    input  ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij,
    input  ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h
  );

  modport slave (
    input  iPixelValid, iFrameStart, iv8Pixel,
    output oReady, oDataValid, oFrameDone,
    output ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij,
    output ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h
  );
endinterface

// File: rtl/window_3x3_generator.sv
// Raster pixel stream to a registered 3x3 neighbourhood using two line buffers and shift taps.
// WINDOW_BORDER_REPLICATE_EN: window for every centre with edge clamping, plus a self-timed flush.
module window_3x3_generator #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic                  iClk,
  input  logic                  iRst,
  window_3x3_generator_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam int PW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

`ifdef WINDOW_BORDER_REPLICATE_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_ONE    = RW'(1);
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
  localparam logic [CW-1:0] COL_TWO = CW'(2);
`endif

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic [CW-1:0]   col_q, col_d, cur_c;
  logic [RW-1:0]   row_q, row_d, cur_r;
  logic [PW-1:0]   wp_q;
  logic            accept, start, take, last_px, shift, flushing, emit, last_emit;
  logic [7:0]      lb_mid [IMG_WIDTH];
  logic [7:0]      lb_top [IMG_WIDTH];
  logic [7:0]      sr_bot [2];
  logic [7:0]      sr_mid [2];
  logic [7:0]      sr_top [2];
  logic [7:0]      tap [3][3];
  logic [7:0]      win_d [9];
  logic [7:0]      win_p1_q [9];
  logic            vld_p1_q, done_p1_q, done_p2_q;
  logic [1:0]      r_up, r_dn, c_lf, c_rt;

  // An edge-clamped neighbour falls back to the centre row/column tap.
  function automatic logic [1:0] clamp_sel(input logic at_edge, input logic [1:0] outer);
    return at_edge ? 2'd1 : outer;
  endfunction

  assign accept  = bus.iPixelValid & ready_q;
  assign start   = accept & bus.iFrameStart;
  assign take    = start | (accept & (state_q == S_RUN));
  assign cur_c   = start ? '0 : col_q;
  assign cur_r   = start ? '0 : row_q;
  assign last_px = take & (cur_r == ROW_LAST) & (cur_c == COL_LAST);
  assign shift   = take | flushing;

`ifdef WINDOW_BORDER_REPLICATE_EN
  logic [CW-1:0] fl_q, cx_q;
  logic [RW-1:0] cy_q;

  assign flushing  = (state_q == S_FLUSH);
  assign emit      = flushing | (take & ((cur_r >= ROW_TWO) | ((cur_r == ROW_ONE) & (cur_c != '0))));
  assign last_emit = flushing & (fl_q == FLUSH_LAST);
  assign r_up      = clamp_sel(cy_q == '0, 2'd0);
  assign r_dn      = clamp_sel(cy_q == ROW_LAST, 2'd2);
  assign c_lf      = clamp_sel(cx_q == '0, 2'd0);
  assign c_rt      = clamp_sel(cx_q == COL_LAST, 2'd2);

  // Centre coordinates trail the input by W+1 beats; tracked directly for clamping.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      fl_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      fl_q <= flushing ? fl_q + CW'(1) : '0;
      if (start) begin
        cx_q <= '0;
        cy_q <= '0;
      end else if (emit) begin
        if (cx_q == COL_LAST) begin
          cx_q <= '0;
          cy_q <= cy_q + RW'(1);
        end else begin
          cx_q <= cx_q + CW'(1);
        end
      end
    end
  end
`else
  assign flushing  = 1'b0;
  assign emit      = take & (cur_r >= ROW_TWO) & (cur_c >= COL_TWO);
  assign last_emit = last_px;
  assign r_up      = clamp_sel(1'b0, 2'd0);
  assign r_dn      = clamp_sel(1'b0, 2'd2);
  assign c_lf      = clamp_sel(1'b0, 2'd0);
  assign c_rt      = clamp_sel(1'b0, 2'd2);
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (take) begin
      if (cur_c == COL_LAST) begin
        col_d = '0;
        row_d = cur_r + RW'(1);
      end else begin
        col_d = cur_c + CW'(1);
        row_d = cur_r;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = 1'b1;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
`ifdef WINDOW_BORDER_REPLICATE_EN
      S_RUN:   if (last_px) state_d = S_FLUSH;
      S_FLUSH: if (fl_q == FLUSH_LAST) state_d = S_IDLE;
`else
      S_RUN:   if (last_px) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef WINDOW_BORDER_REPLICATE_EN
    ready_d = (state_d != S_FLUSH);
`endif
  end

  // Stage p0: delay line. Tap offsets from the newest pixel: 0,1,2 / W,W+1,W+2 / 2W,2W+1,2W+2.
  always_ff @(posedge iClk) begin
    if (shift) begin
      lb_mid[wp_q] <= bus.iv8Pixel;
      lb_top[wp_q] <= lb_mid[wp_q];
      sr_bot[0]    <= bus.iv8Pixel;
      sr_bot[1]    <= sr_bot[0];
      sr_mid[0]    <= lb_mid[wp_q];
      sr_mid[1]    <= sr_mid[0];
      sr_top[0]    <= lb_top[wp_q];
      sr_top[1]    <= sr_top[0];
    end
  end

  always_comb begin
    tap[0][0] = sr_top[1];
    tap[0][1] = sr_top[0];
    tap[0][2] = lb_top[wp_q];
    tap[1][0] = sr_mid[1];
    tap[1][1] = sr_mid[0];
    tap[1][2] = lb_mid[wp_q];
    tap[2][0] = sr_bot[1];
    tap[2][1] = sr_bot[0];
    tap[2][2] = bus.iv8Pixel;
  end

  always_comb begin
    win_d[0] = tap[r_up][c_lf];
    win_d[1] = tap[r_up][1];
    win_d[2] = tap[r_up][c_rt];
    win_d[3] = tap[1][c_lf];
    win_d[4] = tap[1][1];
    win_d[5] = tap[1][c_rt];
    win_d[6] = tap[r_dn][c_lf];
    win_d[7] = tap[r_dn][1];
    win_d[8] = tap[r_dn][c_rt];
  end

  // Stage p1: registered window and control; frame-done trails the last window by one clock.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      wp_q      <= '0;
      vld_p1_q  <= 1'b0;
      done_p1_q <= 1'b0;
      done_p2_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_p1_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      col_q     <= col_d;
      row_q     <= row_d;
      if (shift) wp_q <= (wp_q == PTR_LAST) ? '0 : wp_q + PW'(1);
      vld_p1_q  <= emit;
      done_p1_q <= last_emit;
      done_p2_q <= done_p1_q;
      if (emit) begin
        for (int i = 0; i < 9; i++) win_p1_q[i] <= win_d[i];
      end
    end
  end

  assign bus.oReady       = ready_q;
  assign bus.oDataValid   = vld_p1_q;
  assign bus.oFrameDone   = done_p2_q;
  assign bus.ov8Pixel_a   = win_p1_q[0];
  assign bus.ov8Pixel_b   = win_p1_q[1];
  assign bus.ov8Pixel_c   = win_p1_q[2];
  assign bus.ov8Pixel_d   = win_p1_q[3];
  assign bus.ov8Pixel_fij = win_p1_q[4];
  assign bus.ov8Pixel_e   = win_p1_q[5];
  assign bus.ov8Pixel_f   = win_p1_q[6];
  assign bus.ov8Pixel_g   = win_p1_q[7];
  assign bus.ov8Pixel_h   = win_p1_q[8];
endmodule

// File: tb/tb_window_3x3_generator.sv
// Self-checking bench for window_3x3_generator on a 4x4 image; follows WINDOW_BORDER_REPLICATE_EN.
module tb_window_3x3_generator;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
`ifdef WINDOW_BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  localparam int PER_FRAME = REP ? N : (H - 2) * (W - 2);

  typedef struct packed { logic fs; logic [7:0] px; } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  window_3x3_generator_if bus();
  window_3x3_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.iClk(clk), .iRst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model state: accepted pixels of the current frame, position, flush countdown.
  logic [7:0]  mimg [N];
  int          mk;
  int          flush_rem;
  bit          pend_done, exp_dv, exp_done;
  logic [71:0] last_win;

  beat_t       beats [$];
  logic [71:0] obs_q [$];
  logic [71:0] cont_q [$];
  int          dv_cnt, done_cnt, rdy_low_cnt;

  function automatic logic [71:0] win_of(input int c);
    logic [71:0] w;
    int cy, cx, y, x;
    w  = '0;
    cy = c / W;
    cx = c % W;
    for (int i = 0; i < 9; i++) begin
      y = cy + i / 3 - 1;
      x = cx + i % 3 - 1;
      if (y < 0) y = 0;
      if (y > H - 1) y = H - 1;
      if (x < 0) x = 0;
      if (x > W - 1) x = W - 1;
      w[71 - 8 * i -: 8] = mimg[y * W + x];
    end
    return w;
  endfunction

  function automatic logic [71:0] dut_win();
    return {bus.ov8Pixel_a, bus.ov8Pixel_b, bus.ov8Pixel_c, bus.ov8Pixel_d, bus.ov8Pixel_fij,
            bus.ov8Pixel_e, bus.ov8Pixel_f, bus.ov8Pixel_g, bus.ov8Pixel_h};
  endfunction

  task automatic model_reset();
    mk = -1; flush_rem = 0; pend_done = 0; exp_dv = 0; exp_done = 0; last_win = '0;
  endtask

  task automatic model_step(input bit v, input bit fs, input logic [7:0] px, output bit acc);
    int c;
    exp_done  = pend_done;
    pend_done = 0;
    exp_dv    = 0;
    acc       = v && (flush_rem == 0);
    if (flush_rem > 0) begin
      c = N - flush_rem;
      exp_dv = 1;
      last_win = win_of(c);
      flush_rem--;
      if (flush_rem == 0) pend_done = 1;
    end else if (acc && fs) begin
      mk = 0;
      mimg[0] = px;
    end else if (acc && mk >= 0) begin
      mk++;
      mimg[mk] = px;
      c = mk - (W + 1);
      if (c >= 0 && (REP || (c / W >= 1 && c / W <= H - 2 && c % W >= 1 && c % W <= W - 2))) begin
        exp_dv = 1;
        last_win = win_of(c);
      end
      if (mk == N - 1) begin
        mk = -1;
        if (REP) flush_rem = W + 1;
        else pend_done = 1;
      end
    end
  endtask

  // One clock: drive at posedge+1, check oReady at negedge, check outputs at next posedge+1.
  task automatic cycle(input bit v, input bit fs, input logic [7:0] px, output bit acc);
    bus.iPixelValid = v;
    bus.iFrameStart = v ? fs : 1'($urandom);
    bus.iv8Pixel    = v ? px : 8'($urandom);
    @(negedge clk);
    total++;
    if (bus.oReady !== (flush_rem == 0)) begin
      bad++;
      $display("FAIL ready got=%b exp=%b t=%0t", bus.oReady, (flush_rem == 0), $time);
    end
    if (bus.oReady === 1'b0) rdy_low_cnt++;
    model_step(v, fs, px, acc);
    @(posedge clk);
    #1;
    total++;
    if (bus.oDataValid !== exp_dv) begin
      bad++;
      $display("FAIL data_valid got=%b exp=%b t=%0t", bus.oDataValid, exp_dv, $time);
    end
    total++;
    if (bus.oFrameDone !== exp_done) begin
      bad++;
      $display("FAIL frame_done got=%b exp=%b t=%0t", bus.oFrameDone, exp_done, $time);
    end
    total++;
    if (dut_win() !== last_win) begin
      bad++;
      $display("FAIL window got=%h exp=%h t=%0t", dut_win(), last_win, $time);
    end
    if (bus.oDataValid === 1'b1) begin
      dv_cnt++;
      obs_q.push_back(dut_win());
    end
    if (bus.oFrameDone === 1'b1) done_cnt++;
  endtask

  task automatic run_beats(input int duty);
    int i, budget;
    bit acc, v;
    i = 0;
    budget = 0;
    while (i < beats.size() && budget < 4000) begin
      v = (duty <= 1) ? 1'b1 : ($urandom_range(0, duty - 1) == 0);
      cycle(v, beats[i].fs, beats[i].px, acc);
      if (acc) i++;
      budget++;
    end
    total++;
    if (i != beats.size()) begin
      bad++;
      $display("FAIL stream_budget got=%0d exp=%0d", i, beats.size());
    end
    beats.delete();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, acc);
  endtask

  task automatic load_frame(input int base, input bit rnd, input int first, input int last);
    beat_t b;
    for (int i = first; i <= last; i++) begin
      b.fs = (i == 0);
      b.px = rnd ? 8'($urandom) : 8'(base + i);
      beats.push_back(b);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    dv_cnt = 0;
    done_cnt = 0;
    rdy_low_cnt = 0;
  endtask

  task automatic apply_reset();
    bus.iPixelValid = 1'b0;
    bus.iFrameStart = 1'b0;
    bus.iv8Pixel    = 8'h00;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    total++;
    if ({dut_win(), bus.oDataValid, bus.oFrameDone, bus.oReady} !== 75'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h ready=%b", dut_win(), bus.oReady);
    end
    @(posedge clk);
    #1;
    total++;
    if ({dut_win(), bus.oDataValid, bus.oFrameDone, bus.oReady} !== 75'd0) begin
      bad++;
      $display("FAIL reset_held got=%h ready=%b", dut_win(), bus.oReady);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({bus.oReady, bus.oDataValid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release got=%b exp=10", {bus.oReady, bus.oDataValid});
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_continuous();
    clear_obs();
    load_frame(0, 1'b0, 0, N - 1);
    run_beats(1);
    idle(W + 4);
    total++;
    if (dv_cnt != PER_FRAME) begin
      bad++; $display("FAIL cont_pulses got=%0d exp=%0d", dv_cnt, PER_FRAME);
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL cont_done got=%0d exp=1", done_cnt);
    end
    total++;
    if (obs_q.size() == 0 || obs_q[0] !== (REP ? 72'h00_00_01_00_00_01_04_04_05
                                               : 72'h00_01_02_04_05_06_08_09_0A)) begin
      bad++; $display("FAIL cont_first got=%h", (obs_q.size() > 0) ? obs_q[0] : 72'h0);
    end
    total++;
    if (obs_q.size() == 0 || obs_q[obs_q.size() - 1] !== (REP ? 72'h0A_0B_0B_0E_0F_0F_0E_0F_0F
                                                              : 72'h05_06_07_09_0A_0B_0D_0E_0F)) begin
      bad++; $display("FAIL cont_last got=%h", (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : 72'h0);
    end
    total++;
    if (rdy_low_cnt != (REP ? W + 1 : 0)) begin
      bad++; $display("FAIL cont_ready_low got=%0d exp=%0d", rdy_low_cnt, REP ? W + 1 : 0);
    end
    cont_q = obs_q;
  endtask

  task automatic test_random_duty();
    clear_obs();
    load_frame(0, 1'b0, 0, N - 1);
    run_beats(3);
    idle(W + 4);
    total++;
    if (obs_q.size() != cont_q.size()) begin
      bad++; $display("FAIL duty_count got=%0d exp=%0d", obs_q.size(), cont_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== cont_q[i]) begin
          bad++; $display("FAIL duty_window%0d got=%h exp=%h", i, obs_q[i], cont_q[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] bv;
    load_frame(0, 1'b0, 0, 6);
    run_beats(1);
    clear_obs();
    load_frame(100, 1'b0, 0, N - 1);
    run_beats(1);
    idle(W + 4);
    total++;
    if (dv_cnt != PER_FRAME) begin
      bad++; $display("FAIL abort_pulses got=%0d exp=%0d", dv_cnt, PER_FRAME);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      for (int j = 0; j < 9; j++) begin
        bv = obs_q[i][71 - 8 * j -: 8];
        total++;
        if (bv < 8'd100) begin
          bad++; $display("FAIL abort_old_pixel win=%0d got=%0d exp>=100", i, bv);
        end
      end
    end
  endtask

  task automatic test_idle_ignore();
    beat_t b;
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      b.fs = 1'b0;
      b.px = 8'($urandom);
      beats.push_back(b);
    end
    run_beats(1);
    idle(4);
    total++;
    if (dv_cnt != 0 || done_cnt != 0) begin
      bad++; $display("FAIL idle_ignore got=%0d/%0d exp=0/0", dv_cnt, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    load_frame(0, 1'b1, 0, N - 1);
    load_frame(0, 1'b1, 0, N - 1);
    run_beats(1);
    idle(W + 4);
    total++;
    if (dv_cnt != 2 * PER_FRAME) begin
      bad++; $display("FAIL b2b_pulses got=%0d exp=%0d", dv_cnt, 2 * PER_FRAME);
    end
    total++;
    if (done_cnt != 2) begin
      bad++; $display("FAIL b2b_done got=%0d exp=2", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    load_frame(0, 1'b0, 0, 9);
    run_beats(1);
    apply_reset();
    clear_obs();
    load_frame(0, 1'b0, 0, N - 1);
    run_beats(1);
    idle(W + 4);
    total++;
    if (obs_q.size() != cont_q.size()) begin
      bad++; $display("FAIL rstmid_count got=%0d exp=%0d", obs_q.size(), cont_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== cont_q[i]) begin
          bad++; $display("FAIL rstmid_window%0d got=%h exp=%h", i, obs_q[i], cont_q[i]);
        end
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL rstmid_done got=%0d exp=1", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_random_duty();
    test_abort();
    test_idle_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
